instr_sequencer: RTL

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and runs the valid/ready handshakes to instruction and data memory. It also gates the register-file, memory-write and PC-update strobes so each fires exactly once per instruction. It sits between the combinational `control` decoder, whose outputs it consumes, and the datapath enables.

---
 rtl/cpu_seq_pkg.sv | 24 ++
 rtl/seq_wait_timer.sv | 43 ++++
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer.
// Holds the state encoding (also exported on state_o for debug), the
// writeback-select code that marks a memory writeback, and a helper
// that identifies the memory-wait states covered by the timeout.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_IWAIT  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_DWAIT  = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } seq_state_e;

  localparam logic [1:0] WB_SEL_MEM = 2'b00;

  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_IWAIT) || (s == ST_MEM) || (s == ST_DWAIT);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter for the sequencer's memory-wait states.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   clr_i      restart the count (state change)
//   en_i       count this cycle (sitting in a wait state)
//   expired_o  current cycle is the TIMEOUT_CYC-th cycle of the wait
module seq_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of cycles already spent in the wait, so the
  // TIMEOUT_CYC-th cycle is the one where it equals TIMEOUT_CYC-1.
  assign expired_o = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the RV32I core.
// Steps each instruction through FETCH, IWAIT, DECODE, EXEC, MEM, DWAIT
// and WB, runs the instruction/data memory handshakes and emits one-shot
// datapath strobes. Any memory wait lasting TIMEOUT_CYC cycles without
// completion latches err_o and parks the FSM in HALT until reset.
// Ports:
//   clk_i, rst_i                  clock / synchronous active-high reset
//   imem_rdy_i, imem_valid_i      instruction memory accept / data valid
//   dmem_rdy_i, dmem_valid_i      data memory accept / load data valid
//   mem_wr_ctl_i, rf_en_ctl_i,
//   wb_sel_ctl_i                  decoded controls (stable from DECODE on)
//   imem_req_o, ir_en_o           fetch request / instruction reg latch
//   dmem_req_o, dmem_we_o         data request / request is a write
//   rf_we_o, pc_we_o, retire_o    writeback strobes (WB only)
//   err_o                         sticky memory-timeout error
//   state_o                       current state encoding
//   instret_o                     retired-instruction count (wrapping)
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             imem_rdy_i,
  input  logic             imem_valid_i,
  input  logic             dmem_rdy_i,
  input  logic             dmem_valid_i,
  input  logic             mem_wr_ctl_i,
  input  logic             rf_en_ctl_i,
  input  logic [1:0]       wb_sel_ctl_i,
  output logic             imem_req_o,
  output logic             ir_en_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic             retire_o,
  output logic             err_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  seq_state_e       state_q, state_d;
  logic             is_load_q, is_load_d;
  logic             is_store_q, is_store_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             expired;

  // Restarting on every state change gives a fresh count on entry to each
  // wait state; counting only while in a wait state keeps it frozen elsewhere.
  seq_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_d != state_q),
    .en_i     (is_wait_state(state_q)),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    instret_d  = instret_q;
    imem_req_o = 1'b0;
    ir_en_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    retire_o   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_rdy_i) begin
          state_d = ST_IWAIT;
        end else if (expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end
      ST_IWAIT: begin
        ir_en_o = imem_valid_i;
        if (imem_valid_i) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        // Classification is captured here so MEM's write qualifier comes
        // straight from a register.
        is_load_d  = rf_en_ctl_i && (wb_sel_ctl_i == WB_SEL_MEM) && !mem_wr_ctl_i;
        is_store_d = mem_wr_ctl_i;
        state_d    = (is_load_d || is_store_d) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store_q;
        if (dmem_rdy_i) begin
          state_d = is_load_q ? ST_DWAIT : ST_WB;
        end else if (expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end
      ST_DWAIT: begin
        if (dmem_valid_i) begin
          state_d = ST_WB;
        end else if (expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end
      ST_WB: begin
        rf_we_o   = rf_en_ctl_i;
        pc_we_o   = 1'b1;
        retire_o  = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FETCH;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
      instret_q  <= instret_d;
    end
  end

  assign err_o     = err_q;
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule
